// File: rtl/fb_ctrl_pipe.sv
// fb_ctrl_pipe
// Carries the fb_cu control bundle and register indices from ID through the
// ID/EX, EX/MEM and MEM/WB pipeline registers. It also detects load-use
// hazards, squashes younger work on a taken branch, and produces the ALU
// operand forwarding selects for EX.
//
// Ports
//   clk_i, rst_n_i        clock and synchronous active-low reset
//   id_*_i                ID-stage instruction: valid, rs1/rs2/rd and fb_cu controls
//   flush_i               taken branch resolved in MEM; kills the ID and EX instructions
//   stall_o               hold PC and IF/ID (combinational)
//   ex_*_o                ID/EX register fields
//   mem_*_o               EX/MEM register fields
//   wb_*_o                MEM/WB register fields
//   fwd_a_o, fwd_b_o      operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
module fb_ctrl_pipe #(
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                id_valid_i,
  input  logic [REG_AW-1:0]   id_rs1_i,
  input  logic [REG_AW-1:0]   id_rs2_i,
  input  logic [REG_AW-1:0]   id_rd_i,
  input  logic [ALU_OP_W-1:0] id_alu_op_i,
  input  logic                id_alu_src_i,
  input  logic                id_alu_res_src_i,
  input  logic                id_mem_read_i,
  input  logic                id_mem_write_i,
  input  logic                id_branch_i,
  input  logic                id_mem_to_reg_i,
  input  logic                id_reg_write_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                ex_valid_o,
  output logic [ALU_OP_W-1:0] ex_alu_op_o,
  output logic                ex_alu_src_o,
  output logic                ex_alu_res_src_o,
  output logic [REG_AW-1:0]   ex_rs1_o,
  output logic [REG_AW-1:0]   ex_rs2_o,
  output logic [REG_AW-1:0]   ex_rd_o,
  output logic                mem_valid_o,
  output logic                mem_mem_read_o,
  output logic                mem_mem_write_o,
  output logic                mem_branch_o,
  output logic [REG_AW-1:0]   mem_rd_o,
  output logic                mem_reg_write_o,
  output logic                wb_valid_o,
  output logic                wb_mem_to_reg_o,
  output logic                wb_reg_write_o,
  output logic [REG_AW-1:0]   wb_rd_o,
  output logic [1:0]          fwd_a_o,
  output logic [1:0]          fwd_b_o
);

  typedef struct packed {
    logic                valid;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                alu_res_src;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                mem_to_reg;
    logic                reg_write;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic [REG_AW-1:0]   rd;
  } ex_t;

  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              mem_to_reg;
    logic              reg_write;
    logic [REG_AW-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic              valid;
    logic              mem_to_reg;
    logic              reg_write;
    logic [REG_AW-1:0] rd;
  } wb_t;

  ex_t  ex_q,  ex_d;
  mem_t mem_q, mem_d;
  wb_t  wb_q,  wb_d;
  logic hazard;

  // EX/MEM wins over MEM/WB because it holds the younger result; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input mem_t m, input wb_t w, input logic [REG_AW-1:0] rs);
    if (m.valid && m.reg_write && (m.rd != '0) && (m.rd == rs))
      fwd_sel = 2'b10;
    else if (w.valid && w.reg_write && (w.rd != '0) && (w.rd == rs))
      fwd_sel = 2'b01;
    else
      fwd_sel = 2'b00;
  endfunction

  // Next-state for all three stage registers. A flush outranks a load-use stall,
  // and both turn ID/EX into an all-zero bubble. Side-effect bits of an invalid
  // ID instruction are dropped so that an invalid stage can never write anything.
  always_comb begin
    hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid_i &&
             ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));
    stall_o = hazard && !flush_i;

    ex_d = '0;
    if (!(flush_i || stall_o)) begin
      ex_d.valid       = id_valid_i;
      ex_d.alu_op      = id_alu_op_i;
      ex_d.alu_src     = id_alu_src_i;
      ex_d.alu_res_src = id_alu_res_src_i;
      ex_d.mem_read    = id_mem_read_i  && id_valid_i;
      ex_d.mem_write   = id_mem_write_i && id_valid_i;
      ex_d.branch      = id_branch_i    && id_valid_i;
      ex_d.mem_to_reg  = id_mem_to_reg_i;
      ex_d.reg_write   = id_reg_write_i && id_valid_i;
      ex_d.rs1         = id_rs1_i;
      ex_d.rs2         = id_rs2_i;
      ex_d.rd          = id_rd_i;
    end

    mem_d = '0;
    if (!flush_i) begin
      mem_d.valid      = ex_q.valid;
      mem_d.mem_read   = ex_q.mem_read;
      mem_d.mem_write  = ex_q.mem_write;
      mem_d.branch     = ex_q.branch;
      mem_d.mem_to_reg = ex_q.mem_to_reg;
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.rd         = ex_q.rd;
    end

    wb_d.valid      = mem_q.valid;
    wb_d.mem_to_reg = mem_q.mem_to_reg;
    wb_d.reg_write  = mem_q.reg_write;
    wb_d.rd         = mem_q.rd;
  end

  // Stage registers; reset invalidates every stage on the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign fwd_a_o = fwd_sel(mem_q, wb_q, ex_q.rs1);
  assign fwd_b_o = fwd_sel(mem_q, wb_q, ex_q.rs2);

  assign ex_valid_o       = ex_q.valid;
  assign ex_alu_op_o      = ex_q.alu_op;
  assign ex_alu_src_o     = ex_q.alu_src;
  assign ex_alu_res_src_o = ex_q.alu_res_src;
  assign ex_rs1_o         = ex_q.rs1;
  assign ex_rs2_o         = ex_q.rs2;
  assign ex_rd_o          = ex_q.rd;

  assign mem_valid_o      = mem_q.valid;
  assign mem_mem_read_o   = mem_q.mem_read;
  assign mem_mem_write_o  = mem_q.mem_write;
  assign mem_branch_o     = mem_q.branch;
  assign mem_rd_o         = mem_q.rd;
  assign mem_reg_write_o  = mem_q.reg_write;

  assign wb_valid_o       = wb_q.valid;
  assign wb_mem_to_reg_o  = wb_q.mem_to_reg;
  assign wb_reg_write_o   = wb_q.reg_write;
  assign wb_rd_o          = wb_q.rd;

endmodule

// File: tb/tb_fb_ctrl_pipe.sv
// tb_fb_ctrl_pipe
// Scoreboard bench for fb_ctrl_pipe. Every cycle the driven ID instruction is
// run through a small reference model of the three stages, and the expected
// registered outputs plus forwarding selects are queued. After the clock edge
// the entry is popped and compared with the DUT. Directed scenarios add checks
// against fixed values. The instruction is re-presented whenever a stall is expected.
module tb_fb_ctrl_pipe;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [1:0] aluOp;
    logic       aluSrc;
    logic       aluResSrc;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       memToReg;
    logic       regWrite;
  } instr_t;

  logic clk = 1'b0;
  logic rstN;
  logic flush;
  instr_t idIn;

  logic       stall, exValid, exAluSrc, exAluResSrc;
  logic [1:0] exAluOp, fwdA, fwdB;
  logic [4:0] exRs1, exRs2, exRd, memRd, wbRd;
  logic       memValid, memMemRead, memMemWrite, memBranch, memRegWrite;
  logic       wbValid, wbMemToReg, wbRegWrite;

  instr_t exM = '0, memM = '0, wbM = '0;
  logic [41:0] expQ[$];
  logic [41:0] dutOut;
  logic lastStall;
  logic stallSeen;
  int vectorCount = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  fb_ctrl_pipe #(.REG_AW(5), .ALU_OP_W(2)) dut (
    .clk_i(clk), .rst_n_i(rstN),
    .id_valid_i(idIn.valid), .id_rs1_i(idIn.rs1), .id_rs2_i(idIn.rs2), .id_rd_i(idIn.rd),
    .id_alu_op_i(idIn.aluOp), .id_alu_src_i(idIn.aluSrc), .id_alu_res_src_i(idIn.aluResSrc),
    .id_mem_read_i(idIn.memRead), .id_mem_write_i(idIn.memWrite), .id_branch_i(idIn.branch),
    .id_mem_to_reg_i(idIn.memToReg), .id_reg_write_i(idIn.regWrite),
    .flush_i(flush), .stall_o(stall),
    .ex_valid_o(exValid), .ex_alu_op_o(exAluOp), .ex_alu_src_o(exAluSrc),
    .ex_alu_res_src_o(exAluResSrc), .ex_rs1_o(exRs1), .ex_rs2_o(exRs2), .ex_rd_o(exRd),
    .mem_valid_o(memValid), .mem_mem_read_o(memMemRead), .mem_mem_write_o(memMemWrite),
    .mem_branch_o(memBranch), .mem_rd_o(memRd), .mem_reg_write_o(memRegWrite),
    .wb_valid_o(wbValid), .wb_mem_to_reg_o(wbMemToReg), .wb_reg_write_o(wbRegWrite),
    .wb_rd_o(wbRd), .fwd_a_o(fwdA), .fwd_b_o(fwdB)
  );

  assign dutOut = {exValid, exAluOp, exAluSrc, exAluResSrc, exRs1, exRs2, exRd,
                   memValid, memMemRead, memMemWrite, memBranch, memRd, memRegWrite,
                   wbValid, wbMemToReg, wbRegWrite, wbRd, fwdA, fwdB};

  // Single comparison point: counts every vector and reports each miscompare.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Forwarding as described: younger EX/MEM writer first, then MEM/WB, never x0.
  function automatic logic [1:0] fwdModel(input logic [4:0] rs);
    if (memM.valid && memM.regWrite && memM.rd != 5'd0 && memM.rd == rs) return 2'b10;
    if (wbM.valid && wbM.regWrite && wbM.rd != 5'd0 && wbM.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [41:0] packModel();
    return {exM.valid, exM.aluOp, exM.aluSrc, exM.aluResSrc, exM.rs1, exM.rs2, exM.rd,
            memM.valid, memM.memRead, memM.memWrite, memM.branch, memM.rd, memM.regWrite,
            wbM.valid, wbM.memToReg, wbM.regWrite, wbM.rd, fwdModel(exM.rs1), fwdModel(exM.rs2)};
  endfunction

  function automatic instr_t mkInstr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                     input logic [1:0] aluOp, input logic memRead,
                                     input logic regWrite, input logic branch);
    instr_t r = '0;
    r.valid = 1'b1; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.aluOp = aluOp;
    r.memRead = memRead; r.memToReg = memRead; r.regWrite = regWrite; r.branch = branch;
    return r;
  endfunction

  // Drive one cycle at the negedge, check the combinational stall, push the
  // expected post-edge state, then pop and compare it one tick after the edge.
  task automatic applyStimulus(input instr_t in, input logic fl);
    logic haz;
    logic [41:0] expVal;
    instr_t g;
    idIn = in;
    flush = fl;
    #1;
    haz = exM.valid && exM.memRead && exM.rd != 5'd0 && in.valid &&
          (exM.rd == in.rs1 || exM.rd == in.rs2);
    lastStall = haz && !fl;
    stallSeen = stall;
    checkOutput("stall", {63'd0, stall}, {63'd0, lastStall});
    g = in;
    if (!in.valid) begin
      g.memRead = 1'b0; g.memWrite = 1'b0; g.branch = 1'b0; g.regWrite = 1'b0;
    end
    if (!rstN) begin
      exM = '0; memM = '0; wbM = '0;
    end else begin
      wbM  = memM;
      memM = fl ? '0 : exM;
      exM  = (fl || lastStall) ? '0 : g;
    end
    expQ.push_back(packModel());
    @(posedge clk);
    #1;
    expVal = expQ.pop_front();
    checkOutput("pipe", {22'd0, dutOut}, {22'd0, expVal});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    instr_t nop, rType, ld, cons, br, x, y, cur;
    nop = '0;

    // Reset held two cycles with everything in ID driven high.
    rstN = 1'b0;
    flush = 1'b0;
    idIn = '1;
    @(posedge clk);
    @(negedge clk);
    applyStimulus('1, 1'b0);
    checkOutput("rst_fwd", {60'd0, fwdA, fwdB}, 64'd0);
    checkOutput("rst_valids", {61'd0, exValid, memValid, wbValid}, 64'd0);
    rstN = 1'b1;

    // Single R-type walks EX -> MEM -> WB, then the pipe empties.
    rType = mkInstr(5'd1, 5'd2, 5'd5, 2'b10, 1'b0, 1'b1, 1'b0);
    applyStimulus(rType, 1'b0);
    checkOutput("prop_ex_aluop", {62'd0, exAluOp}, 64'd2);
    applyStimulus(nop, 1'b0);
    checkOutput("prop_mem", {58'd0, memRegWrite, memRd}, {58'd0, 1'b1, 5'd5});
    applyStimulus(nop, 1'b0);
    checkOutput("prop_wb", {58'd0, wbRegWrite, wbRd}, {58'd0, 1'b1, 5'd5});
    applyStimulus(nop, 1'b0);
    checkOutput("prop_empty", {61'd0, exValid, memValid, wbValid}, 64'd0);

    // Load rd=3 followed by a consumer of x3 on rs2: one stall, one bubble.
    ld   = mkInstr(5'd1, 5'd0, 5'd3, 2'b00, 1'b1, 1'b1, 1'b0);
    cons = mkInstr(5'd4, 5'd3, 5'd6, 2'b10, 1'b0, 1'b1, 1'b0);
    applyStimulus(ld, 1'b0);
    applyStimulus(cons, 1'b0);
    checkOutput("lu_stall", {63'd0, stallSeen}, 64'd1);
    checkOutput("lu_bubble", {63'd0, exValid}, 64'd0);
    applyStimulus(cons, 1'b0);
    checkOutput("lu_release", {63'd0, stallSeen}, 64'd0);
    checkOutput("lu_fwd_b", {62'd0, fwdB}, 64'd1);

    // Forwarding priority with rd=7 in MEM and WB, then MEM moved to rd=8, then x0.
    applyStimulus(mkInstr(5'd1, 5'd2, 5'd7, 2'b10, 1'b0, 1'b1, 1'b0), 1'b0);
    applyStimulus(mkInstr(5'd1, 5'd2, 5'd7, 2'b10, 1'b0, 1'b1, 1'b0), 1'b0);
    applyStimulus(mkInstr(5'd7, 5'd2, 5'd9, 2'b10, 1'b0, 1'b1, 1'b0), 1'b0);
    checkOutput("fwd_a_mem", {62'd0, fwdA}, 64'd2);
    applyStimulus(mkInstr(5'd1, 5'd2, 5'd7, 2'b10, 1'b0, 1'b1, 1'b0), 1'b0);
    applyStimulus(mkInstr(5'd1, 5'd2, 5'd8, 2'b10, 1'b0, 1'b1, 1'b0), 1'b0);
    applyStimulus(mkInstr(5'd7, 5'd2, 5'd9, 2'b10, 1'b0, 1'b1, 1'b0), 1'b0);
    checkOutput("fwd_a_wb", {62'd0, fwdA}, 64'd1);
    applyStimulus(mkInstr(5'd1, 5'd2, 5'd0, 2'b10, 1'b0, 1'b1, 1'b0), 1'b0);
    applyStimulus(mkInstr(5'd1, 5'd2, 5'd0, 2'b10, 1'b0, 1'b1, 1'b0), 1'b0);
    applyStimulus(mkInstr(5'd0, 5'd2, 5'd9, 2'b10, 1'b0, 1'b1, 1'b0), 1'b0);
    checkOutput("fwd_a_x0", {62'd0, fwdA}, 64'd0);

    // Branch reaches MEM with X in EX and Y in ID when flush fires.
    br = mkInstr(5'd1, 5'd2, 5'd0, 2'b01, 1'b0, 1'b0, 1'b1);
    x  = mkInstr(5'd1, 5'd2, 5'd9, 2'b10, 1'b0, 1'b1, 1'b0);
    y  = mkInstr(5'd3, 5'd4, 5'd10, 2'b10, 1'b0, 1'b1, 1'b0);
    applyStimulus(br, 1'b0);
    applyStimulus(x, 1'b0);
    applyStimulus(y, 1'b1);
    checkOutput("flush_valids", {61'd0, exValid, memValid, wbValid}, 64'd1);

    // Load-use hazard and flush together: flush wins, no stall.
    applyStimulus(br, 1'b0);
    applyStimulus(ld, 1'b0);
    applyStimulus(cons, 1'b1);
    checkOutput("both_stall", {63'd0, stallSeen}, 64'd0);
    checkOutput("both_valids", {61'd0, exValid, memValid, wbValid}, 64'd1);

    // Reset in the middle of a stream clears every stage on that edge.
    applyStimulus(x, 1'b0);
    applyStimulus(y, 1'b0);
    rstN = 1'b0;
    applyStimulus(x, 1'b0);
    checkOutput("mid_rst_valids", {61'd0, exValid, memValid, wbValid}, 64'd0);
    rstN = 1'b1;

    // Random traffic over a small register set; a stalled instruction is held.
    lastStall = 1'b0;
    cur = '0;
    for (int i = 0; i < 80; i++) begin
      if (!lastStall) begin
        cur.valid     = ($urandom_range(0, 3) != 0);
        cur.rs1       = 5'($urandom_range(0, 3));
        cur.rs2       = 5'($urandom_range(0, 3));
        cur.rd        = 5'($urandom_range(0, 3));
        cur.aluOp     = 2'($urandom_range(0, 3));
        cur.aluSrc    = 1'($urandom_range(0, 1));
        cur.aluResSrc = 1'($urandom_range(0, 1));
        cur.memRead   = 1'($urandom_range(0, 1));
        cur.memWrite  = 1'($urandom_range(0, 1));
        cur.branch    = 1'($urandom_range(0, 1));
        cur.memToReg  = 1'($urandom_range(0, 1));
        cur.regWrite  = 1'($urandom_range(0, 1));
      end
      applyStimulus(cur, ($urandom_range(0, 7) == 0));
    end

    for (int i = 0; i < 3; i++) applyStimulus(nop, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
